// File: rtl/route_pkg.sv
// Shared route constants: city coordinate tables and the Manhattan leg metric
// used by the tour evaluator and the mutation/crossover blocks.
package route_pkg;

    localparam int COORD_W    = 8;
    localparam int TBL_CITY_W = 5;
    localparam int NUM_TBL    = 1 << TBL_CITY_W;
    localparam int LEGDIST_W  = COORD_W + 1;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_e;

    localparam coord_t CITY_X [NUM_TBL] = '{
        8'd0,   8'd8,   8'd16,  8'd24,  8'd32,  8'd40,  8'd48,  8'd56,
        8'd64,  8'd72,  8'd80,  8'd88,  8'd96,  8'd104, 8'd112, 8'd120,
        8'd128, 8'd136, 8'd144, 8'd152, 8'd160, 8'd168, 8'd176, 8'd184,
        8'd192, 8'd200, 8'd208, 8'd216, 8'd224, 8'd232, 8'd240, 8'd248
    };

    localparam coord_t CITY_Y [NUM_TBL] = '{
        8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
        8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
        8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
        8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0
    };

    function automatic logic [LEGDIST_W-1:0] legdist(
        input logic [TBL_CITY_W-1:0] a,
        input logic [TBL_CITY_W-1:0] b
    );
        coord_t dx;
        coord_t dy;
        dx = (CITY_X[a] > CITY_X[b]) ? CITY_X[a] - CITY_X[b] : CITY_X[b] - CITY_X[a];
        dy = (CITY_Y[a] > CITY_Y[b]) ? CITY_Y[a] - CITY_Y[b] : CITY_Y[b] - CITY_Y[a];
        return {1'b0, dx} + {1'b0, dy};
    endfunction

endpackage

// File: rtl/tour_lane.sv
// One shared lane: saturating accumulator of leg distances with a clear.
// sum_o is the running total including the leg presented this cycle.
module tour_lane
    import route_pkg::*;
#(
    parameter int DIST_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [LEGDIST_W-1:0] leg_i,
    output logic [DIST_W-1:0]    sum_o
);

    logic [DIST_W-1:0] acc_q;
    logic [DIST_W-1:0] acc_d;
    logic [DIST_W:0]   raw_sum;

    // One extra bit catches the carry-out; a single leg can never overflow it twice.
    assign raw_sum = {1'b0, acc_q} + (DIST_W + 1)'(leg_i);
    assign sum_o   = raw_sum[DIST_W] ? '1 : raw_sum[DIST_W-1:0];

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pop_distance_sched.sv
// Time-multiplexed closed-tour length evaluator: LANES lane units sweep the
// population batch by batch, one leg per cycle, and track the shortest tour.
module pop_distance_sched
    import route_pkg::*;
#(
    parameter int POP_SIZE   = 25,
    parameter int NUM_CITIES = 15,
    parameter int CITY_W     = 5,
    parameter int DIST_W     = 12,
    parameter int LANES      = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [POP_SIZE*NUM_CITIES*CITY_W-1:0] pop,
    output logic [POP_SIZE*DIST_W-1:0]           distances,
    output logic [$clog2(POP_SIZE)-1:0]          best_idx,
    output logic [DIST_W-1:0]                    best_dist,
    output logic                                 busy,
    output logic                                 done
);

    localparam int IND_W     = NUM_CITIES * CITY_W;
    localparam int POP_W     = POP_SIZE * IND_W;
    localparam int IDX_W     = $clog2(POP_SIZE);
    localparam int NUM_BATCH = (POP_SIZE + LANES - 1) / LANES;
    localparam int BATCH_W   = (NUM_BATCH > 1) ? $clog2(NUM_BATCH) : 1;
    localparam int LEG_W     = (NUM_CITIES > 1) ? $clog2(NUM_CITIES) : 1;

    localparam logic [LEG_W-1:0]   LEG_LAST   = LEG_W'(NUM_CITIES - 1);
    localparam logic [BATCH_W-1:0] BATCH_LAST = BATCH_W'(NUM_BATCH - 1);

    sched_state_e                 state_q, state_d;
    logic [BATCH_W-1:0]           batch_q, batch_d;
    logic [LEG_W-1:0]             leg_q, leg_d;
    logic [POP_W-1:0]             pop_q, pop_d;
    logic [POP_SIZE*DIST_W-1:0]   dist_q, dist_d;
    logic [IDX_W-1:0]             best_idx_q, best_idx_d;
    logic [DIST_W-1:0]            best_dist_q, best_dist_d;

    logic [LEG_W-1:0]             leg_nxt;
    logic [LANES-1:0]             lane_active;
    logic [LANES-1:0]             lane_en;
    logic                         lane_clr;
    int                           lane_ind [LANES];
    logic [LEGDIST_W-1:0]         leg_val  [LANES];
    logic [DIST_W-1:0]            lane_sum [LANES];
    logic [DIST_W-1:0]            cand_dist;
    logic [IDX_W-1:0]             cand_idx;

    assign leg_nxt = (leg_q == LEG_LAST) ? '0 : leg_q + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            int               ind;
            int               base;
            logic [CITY_W-1:0] city_a;
            logic [CITY_W-1:0] city_b;

            assign ind             = int'(batch_q) * LANES + gi;
            assign lane_ind[gi]    = ind;
            assign lane_active[gi] = (ind < POP_SIZE);
            // Inactive lanes read individual 0 so the slice never leaves pop_q.
            assign base   = (lane_active[gi] ? ind : 0) * IND_W;
            assign city_a = pop_q[base + int'(leg_q) * CITY_W +: CITY_W];
            assign city_b = pop_q[base + int'(leg_nxt) * CITY_W +: CITY_W];
            assign leg_val[gi] = legdist(TBL_CITY_W'(city_a), TBL_CITY_W'(city_b));

            tour_lane #(
                .DIST_W (DIST_W)
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .clr_i (lane_clr),
                .en_i  (lane_en[gi]),
                .leg_i (leg_val[gi]),
                .sum_o (lane_sum[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        batch_d     = batch_q;
        leg_d       = leg_q;
        pop_d       = pop_q;
        dist_d      = dist_q;
        best_idx_d  = best_idx_q;
        best_dist_d = best_dist_q;
        lane_clr    = 1'b0;
        lane_en     = '0;
        cand_dist   = best_dist_q;
        cand_idx    = best_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pop_d       = pop;
                    dist_d      = '0;
                    best_dist_d = '1;
                    best_idx_d  = '0;
                    batch_d     = '0;
                    leg_d       = '0;
                    lane_clr    = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                lane_en = lane_active;
                if (leg_q == LEG_LAST) begin
                    // Stored best always has a lower index than this batch, so a
                    // strict compare in ascending lane order keeps the lowest index on ties.
                    for (int j = 0; j < LANES; j++) begin
                        if (lane_active[j]) begin
                            dist_d[lane_ind[j]*DIST_W +: DIST_W] = lane_sum[j];
                            if (lane_sum[j] < cand_dist) begin
                                cand_dist = lane_sum[j];
                                cand_idx  = IDX_W'(lane_ind[j]);
                            end
                        end
                    end
                    best_dist_d = cand_dist;
                    best_idx_d  = cand_idx;
                    leg_d       = '0;
                    lane_clr    = 1'b1;
                    if (batch_q == BATCH_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        batch_d = batch_q + 1'b1;
                    end
                end else begin
                    leg_d = leg_nxt;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            batch_q     <= '0;
            leg_q       <= '0;
            pop_q       <= '0;
            dist_q      <= '0;
            best_idx_q  <= '0;
            best_dist_q <= '0;
        end else begin
            state_q     <= state_d;
            batch_q     <= batch_d;
            leg_q       <= leg_d;
            pop_q       <= pop_d;
            dist_q      <= dist_d;
            best_idx_q  <= best_idx_d;
            best_dist_q <= best_dist_d;
        end
    end

    assign distances = dist_q;
    assign best_idx  = best_idx_q;
    assign best_dist = best_dist_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);

endmodule
